// File: rtl/spi_seq_pkg.sv
// Shared types and default parameters for the SPI byte sequencer.
// Optional feature macro used by the top: SPI_SEQ_STATS_EN.
package spi_seq_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEF_FIFO_DEPTH   = 8;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_CS_HOLD_CLKS = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RX = 2'd2,
    CS_HOLD = 2'd3
  } seq_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous show-ahead FIFO. The head is a registered read of the storage
// array, refreshed with the entry that will be at the front after each edge.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Wr_En,
  input  logic [WIDTH-1:0] i_Wr_Data,
  input  logic             i_Rd_En,
  output logic [WIDTH-1:0] o_Rd_Data,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      rd_ptr_next;
  logic [WIDTH-1:0] head_reg;
  logic             do_push;
  logic             do_pop;

  assign o_Empty     = (wr_ptr_reg == rd_ptr_reg);
  assign o_Full      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                       (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign do_pop      = i_Rd_En && !o_Empty;
  // A full FIFO still accepts a write when the same edge frees a slot.
  assign do_push     = i_Wr_En && (!o_Full || do_pop);
  assign rd_ptr_next = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
  assign o_Rd_Data   = head_reg;

  always_ff @(posedge i_Clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= i_Wr_Data;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      // Bypass when the entry being written becomes the new head.
      if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
        head_reg <= i_Wr_Data;
      end else if (rd_ptr_next != wr_ptr_reg) begin
        head_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds an SPI controller from a TX FIFO in N-byte bursts under one CS_n window
// and gathers replies into an RX FIFO. Define SPI_SEQ_STATS_EN to add o_Xfer_Cnt.
module spi_byte_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int CS_HOLD_CLKS = DEF_CS_HOLD_CLKS
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [BYTE_W-1:0] i_Wr_Byte,
  input  logic              i_Wr_DV,
  output logic              o_Wr_Full,
  input  logic              i_Start,
  input  logic [CNT_W-1:0]  i_Len,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Overflow,
  output logic [BYTE_W-1:0] o_Rd_Byte,
  output logic              o_Rd_Empty,
  input  logic              i_Rd_En,
  output logic [BYTE_W-1:0] o_TX_Byte,
  output logic              o_TX_DV,
  input  logic              i_TX_Ready,
  input  logic              i_RX_DV,
  input  logic [BYTE_W-1:0] i_RX_Byte,
  output logic              o_CS_n
`ifdef SPI_SEQ_STATS_EN
  ,
  output logic [15:0]       o_Xfer_Cnt
`endif
);

  localparam int HOLD_W = $clog2(CS_HOLD_CLKS + 1);

  seq_state_e        state_reg;
  logic [CNT_W-1:0]  remaining_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [BYTE_W-1:0] tx_byte_reg;
  logic              tx_dv_reg;
  logic              cs_n_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              overflow_reg;

  logic [BYTE_W-1:0] tx_head;
  logic              tx_empty;
  logic              tx_pop;
  logic              rx_push;
  logic              rx_full;

  assign tx_pop  = (state_reg == ISSUE) && i_TX_Ready && !tx_empty;
  assign rx_push = (state_reg == WAIT_RX) && i_RX_DV;

  spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Wr_En   (i_Wr_DV),
    .i_Wr_Data (i_Wr_Byte),
    .i_Rd_En   (tx_pop),
    .o_Rd_Data (tx_head),
    .o_Full    (o_Wr_Full),
    .o_Empty   (tx_empty)
  );

  spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Wr_En   (rx_push),
    .i_Wr_Data (i_RX_Byte),
    .i_Rd_En   (i_Rd_En),
    .o_Rd_Data (o_Rd_Byte),
    .o_Full    (rx_full),
    .o_Empty   (o_Rd_Empty)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      hold_cnt_reg  <= '0;
      tx_byte_reg   <= '0;
      tx_dv_reg     <= 1'b0;
      cs_n_reg      <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      tx_dv_reg <= 1'b0;
      done_reg  <= 1'b0;
      // A same-cycle host read frees a slot, so that reply is not lost.
      if (rx_push && rx_full && !i_Rd_En) begin
        overflow_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (i_Start && (i_Len != '0)) begin
            state_reg     <= ISSUE;
            remaining_reg <= i_Len;
            cs_n_reg      <= 1'b0;
            busy_reg      <= 1'b1;
            overflow_reg  <= 1'b0;
          end
        end
        ISSUE: begin
          if (tx_pop) begin
            tx_byte_reg <= tx_head;
            tx_dv_reg   <= 1'b1;
            state_reg   <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (i_RX_DV) begin
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == CNT_W'(1)) begin
              state_reg    <= CS_HOLD;
              cs_n_reg     <= 1'b1;
              hold_cnt_reg <= '0;
            end else begin
              state_reg <= ISSUE;
            end
          end
        end
        CS_HOLD: begin
          if (hold_cnt_reg == HOLD_W'(CS_HOLD_CLKS)) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_TX_Byte  = tx_byte_reg;
  assign o_TX_DV    = tx_dv_reg;
  assign o_CS_n     = cs_n_reg;
  assign o_Busy     = busy_reg;
  assign o_Done     = done_reg;
  assign o_Overflow = overflow_reg;

`ifdef SPI_SEQ_STATS_EN
  logic [15:0] xfer_cnt_reg;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      xfer_cnt_reg <= '0;
    end else if (rx_push && (xfer_cnt_reg != 16'hFFFF)) begin
      xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
    end
  end

  assign o_Xfer_Cnt = xfer_cnt_reg;
`endif

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Randomised bench for spi_byte_sequencer: a queue-based model of the host side
// and a behavioural SPI controller that answers each data-valid pulse.
module tb_spi_byte_sequencer;

  localparam int DEPTH = 8;
  localparam int HOLD  = 2;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic [7:0] i_Wr_Byte = '0;
  logic       i_Wr_DV = 1'b0;
  logic       o_Wr_Full;
  logic       i_Start = 1'b0;
  logic [7:0] i_Len = '0;
  logic       o_Busy, o_Done, o_Overflow;
  logic [7:0] o_Rd_Byte;
  logic       o_Rd_Empty;
  logic       i_Rd_En = 1'b0;
  logic [7:0] o_TX_Byte;
  logic       o_TX_DV;
  logic       i_TX_Ready = 1'b1;
  logic       i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = '0;
  logic       o_CS_n;
`ifdef SPI_SEQ_STATS_EN
  logic [15:0] o_Xfer_Cnt;
`endif

  spi_byte_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(8), .CS_HOLD_CLKS(HOLD)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Wr_Byte  (i_Wr_Byte),
    .i_Wr_DV    (i_Wr_DV),
    .o_Wr_Full  (o_Wr_Full),
    .i_Start    (i_Start),
    .i_Len      (i_Len),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Overflow (o_Overflow),
    .o_Rd_Byte  (o_Rd_Byte),
    .o_Rd_Empty (o_Rd_Empty),
    .i_Rd_En    (i_Rd_En),
    .o_TX_Byte  (o_TX_Byte),
    .o_TX_DV    (o_TX_DV),
    .i_TX_Ready (i_TX_Ready),
    .i_RX_DV    (i_RX_DV),
    .i_RX_Byte  (i_RX_Byte),
    .o_CS_n     (o_CS_n)
`ifdef SPI_SEQ_STATS_EN
    ,
    .o_Xfer_Cnt (o_Xfer_Cnt)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] fix_rx[$];
  int   cyc         = 0;
  int   reply_cd    = -1;
  int   rem_model   = 0;
  int   last_rx_cyc = -100;
  int   dv_cnt      = 0;
  int   cs_falls    = 0;
  int   xfer_total  = 0;
  bit   model_busy  = 0;
  bit   model_ovf   = 0;
  bit   expect_done = 0;
  bit   done_flag   = 0;
  bit   prev_dv     = 0;
  bit   prev_cs     = 1;
  bit   rand_ready  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // One clock: sample DUT after the edge, run the controller and model, set next inputs.
  task automatic cycle();
    logic rdy_edge;
    rdy_edge = i_TX_Ready;
    @(posedge i_Clk);
    #1;
    cyc++;
    if (o_TX_DV === 1'b1) begin
      chk("dv_width", prev_dv, 0);
      chk("dv_before_rx", (reply_cd >= 0) ? 1 : 0, 0);
      chk("dv_ready", rdy_edge, 1);
      chk("cs_during_dv", o_CS_n, 0);
      if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
      else chk("tx_byte", o_TX_Byte, exp_tx.pop_front());
      $display("[%0d] tx byte %02h", cyc, o_TX_Byte);
      dv_cnt++;
      reply_cd = $urandom_range(0, 3);
    end
    if (o_Done === 1'b1) begin
      chk("done_expected", expect_done, 1);
      chk("done_timing", cyc - last_rx_cyc, HOLD + 1);
      chk("done_busy", o_Busy, 0);
      $display("[%0d] burst done", cyc);
      expect_done = 0;
      model_busy  = 0;
      done_flag   = 1;
    end
    if (expect_done && cyc == last_rx_cyc) chk("cs_release", o_CS_n, 1);
    if (prev_cs && o_CS_n === 1'b0) cs_falls++;
    prev_dv = (o_TX_DV === 1'b1);
    prev_cs = (o_CS_n !== 1'b0);
    i_RX_DV = 1'b0;
    if (reply_cd == 0) begin
      i_RX_DV   = 1'b1;
      i_RX_Byte = (fix_rx.size() != 0) ? fix_rx.pop_front() : 8'($urandom);
      reply_cd  = -1;
      xfer_total++;
      if (exp_rx.size() < DEPTH) exp_rx.push_back(i_RX_Byte);
      else model_ovf = 1;
      rem_model--;
      if (rem_model == 0) begin
        expect_done = 1;
        last_rx_cyc = cyc + 1;
      end
    end else if (reply_cd > 0) begin
      reply_cd--;
    end
    if (rand_ready) i_TX_Ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    while (o_Wr_Full === 1'b1 && guard < 200) begin
      cycle();
      guard++;
    end
    if (guard >= 200) chk("wr_full_timeout", guard, 0);
    i_Wr_DV   = 1'b1;
    i_Wr_Byte = b;
    exp_tx.push_back(b);
    cycle();
    i_Wr_DV = 1'b0;
  endtask

  task automatic start_burst(input int len);
    bit accept;
    accept = (len != 0) && !model_busy;
    if (accept) begin
      dv_cnt    = 0;
      cs_falls  = 0;
      done_flag = 0;
    end
    i_Start = 1'b1;
    i_Len   = 8'(len);
    cycle();
    i_Start = 1'b0;
    if (accept) begin
      rem_model  = len;
      model_ovf  = 0;
      model_busy = 1;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_flag && n < budget) begin
      cycle();
      n++;
    end
    if (!done_flag) chk("done_timeout", 0, 1);
    chk("tx_left", exp_tx.size(), 0);
  endtask

  task automatic drain();
    while (exp_rx.size() != 0) begin
      chk("rd_empty_busy", o_Rd_Empty, 0);
      chk("rd_byte", o_Rd_Byte, exp_rx.pop_front());
      i_Rd_En = 1'b1;
      cycle();
      i_Rd_En = 1'b0;
    end
    chk("rd_empty_end", o_Rd_Empty, 1);
  endtask

  initial begin
    int guard;
    repeat (3) cycle();
    // reset values
    chk("rst_cs", o_CS_n, 1);
    chk("rst_dv", o_TX_DV, 0);
    chk("rst_txbyte", o_TX_Byte, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_done", o_Done, 0);
    chk("rst_ovf", o_Overflow, 0);
    chk("rst_full", o_Wr_Full, 0);
    chk("rst_empty", o_Rd_Empty, 1);
    chk("rst_rdbyte", o_Rd_Byte, 0);
    i_Rst = 1'b0;
    cycle();

    // reset in the middle of a burst
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    start_burst(3);
    guard = 0;
    while (dv_cnt == 0 && guard < 50) begin cycle(); guard++; end
    chk("mid_dv_seen", dv_cnt, 1);
    cycle();
    i_Rst = 1'b1;
    cycle();
    chk("mid_rst_cs", o_CS_n, 1);
    chk("mid_rst_dv", o_TX_DV, 0);
    chk("mid_rst_busy", o_Busy, 0);
    chk("mid_rst_empty", o_Rd_Empty, 1);
    chk("mid_rst_full", o_Wr_Full, 0);
    chk("mid_rst_done", o_Done, 0);
    exp_tx.delete(); exp_rx.delete();
    reply_cd = -1; rem_model = 0; expect_done = 0; model_busy = 0;
    xfer_total = 0; prev_dv = 0;
    i_RX_DV = 1'b0;
    i_Rst = 1'b0;
    repeat (6) cycle();
    chk("post_rst_busy", o_Busy, 0);

    // basic burst with fixed replies
    push_byte(8'hA5); push_byte(8'h3C);
    fix_rx.push_back(8'h11); fix_rx.push_back(8'h22);
    start_burst(2);
    chk("start_busy", o_Busy, 1);
    chk("start_cs", o_CS_n, 0);
    chk("start_dv_setup", o_TX_DV, 0);
    cycle();
    chk("first_dv", o_TX_DV, 1);
    wait_done(100);
    chk("basic_dv_cnt", dv_cnt, 2);
    chk("basic_cs_win", cs_falls, 1);
    chk("basic_rx0", o_Rd_Byte, 8'h11);
    drain();

    // underrun: only one byte available for a three-byte burst
    push_byte(8'h5A);
    start_burst(3);
    repeat (20) cycle();
    chk("underrun_cs", o_CS_n, 0);
    chk("underrun_busy", o_Busy, 1);
    chk("underrun_dv_cnt", dv_cnt, 1);
    push_byte(8'h6B); push_byte(8'h7C);
    wait_done(200);
    chk("underrun_total_dv", dv_cnt, 3);
    chk("underrun_cs_win", cs_falls, 1);
    drain();

    // ready back-pressure
    i_TX_Ready = 1'b0;
    push_byte(8'hC1); push_byte(8'hC2);
    start_burst(2);
    repeat (10) cycle();
    chk("bp_no_dv", dv_cnt, 0);
    i_TX_Ready = 1'b1;
    cycle();
    chk("bp_dv_after_ready", o_TX_DV, 1);
    wait_done(200);
    drain();

    // RX overflow: ten replies into an eight-entry FIFO with no reads
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h40 + i));
    chk("tx_full", o_Wr_Full, 1);
    start_burst(10);
    push_byte(8'h48); push_byte(8'h49);
    wait_done(500);
    chk("ovf_flag", o_Overflow, model_ovf);
    chk("ovf_stored", exp_rx.size(), DEPTH);
    drain();
    push_byte(8'hEE);
    start_burst(1);
    chk("ovf_cleared", o_Overflow, 0);
    wait_done(100);
    drain();

    // zero length and start while busy
    start_burst(0);
    chk("len0_busy", o_Busy, 0);
    chk("len0_cs", o_CS_n, 1);
    repeat (3) cycle();
    chk("len0_idle", o_Busy, 0);
    push_byte(8'h91); push_byte(8'h92);
    start_burst(2);
    cycle(); cycle();
    start_burst(5);
    wait_done(200);
    chk("busy_start_dv_cnt", dv_cnt, 2);
    cycle();
    chk("busy_start_idle", o_Busy, 0);
    drain();

    // random bursts with random ready
    rand_ready = 1;
    for (int b = 0; b < 6; b++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) push_byte(8'($urandom));
      start_burst(len);
      wait_done(400);
      chk("rand_dv_cnt", dv_cnt, len);
      chk("rand_cs_win", cs_falls, 1);
      drain();
    end
    rand_ready = 0;
    i_TX_Ready = 1'b1;

`ifdef SPI_SEQ_STATS_EN
    chk("xfer_cnt", o_Xfer_Cnt, xfer_total);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
